// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry registered issue stage between RV32I decode and the ALU.
// Each accepted instruction is decoded combinationally into ALU operands, an
// ALU control code and writeback/branch side information. The result is held
// in one output register slot that obeys a valid/ready handshake.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    upstream (decode) handshake
//   instr, pc              instruction word and its address
//   rs1_data, rs2_data     register-file read data
//   flush                  drop the held slot and any simultaneous input
//   out_valid / out_ready  downstream (execute) handshake
//   srca, srcb, aluCtrl    ALU operand and control inputs
//   rd, reg_write          destination register and write enable
//   is_branch, is_jump     control-transfer flags
//   branch_target          branch/jump target address
//   illegal                instruction could not be decoded
//
// Only XLEN = 32 is supported; the immediates are built for RV32I.
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] srca,
    output logic [XLEN-1:0] srcb,
    output logic [5:0]      aluCtrl,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic            is_jump,
    output logic [XLEN-1:0] branch_target,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_XOR  = 6'd2;
    localparam logic [5:0] ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SRL  = 6'd4;
    localparam logic [5:0] ALU_SRA  = 6'd5;
    localparam logic [5:0] ALU_AND  = 6'd6;
    localparam logic [5:0] ALU_OR   = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_BEQ  = 6'd9;
    localparam logic [5:0] ALU_BNE  = 6'd10;
    localparam logic [5:0] ALU_BLT  = 6'd11;
    localparam logic [5:0] ALU_BGE  = 6'd12;
    localparam logic [5:0] ALU_SLTU = 6'd13;
    localparam logic [5:0] ALU_BLTU = 6'd14;
    localparam logic [5:0] ALU_BGEU = 6'd15;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Field extraction and immediates
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] shamt_imm;
    logic [31:0] shamt_reg;
    logic [31:0] jalr_sum;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rd_field  = instr[11:7];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // The ALU shifts by the whole of srcb, so shift amounts are trimmed here.
    assign shamt_imm = {27'b0, instr[24:20]};
    assign shamt_reg = {27'b0, rs2_data[4:0]};
    assign jalr_sum  = rs1_data + imm_i;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [31:0] dec_srca;
    logic [31:0] dec_srcb;
    logic [5:0]  dec_ctrl;
    logic        dec_rw;
    logic        dec_br;
    logic        dec_jp;
    logic [31:0] dec_tgt;
    logic        dec_ill;

    always_comb begin
        dec_srca = '0;
        dec_srcb = '0;
        dec_ctrl = ALU_ADD;
        dec_rw   = 1'b0;
        dec_br   = 1'b0;
        dec_jp   = 1'b0;
        dec_tgt  = '0;
        dec_ill  = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                dec_srca = rs1_data;
                dec_srcb = rs2_data;
                dec_rw   = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_ctrl = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_ctrl = ALU_SUB;
                    {F7_BASE, 3'b001}: begin dec_ctrl = ALU_SLL; dec_srcb = shamt_reg; end
                    {F7_BASE, 3'b010}: dec_ctrl = ALU_SLT;
                    {F7_BASE, 3'b011}: dec_ctrl = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec_ctrl = ALU_XOR;
                    {F7_BASE, 3'b101}: begin dec_ctrl = ALU_SRL; dec_srcb = shamt_reg; end
                    {F7_ALT,  3'b101}: begin dec_ctrl = ALU_SRA; dec_srcb = shamt_reg; end
                    {F7_BASE, 3'b110}: dec_ctrl = ALU_OR;
                    {F7_BASE, 3'b111}: dec_ctrl = ALU_AND;
                    default:           dec_ill  = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_srca = rs1_data;
                dec_srcb = imm_i;
                dec_rw   = 1'b1;
                case (funct3)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b110: dec_ctrl = ALU_OR;
                    3'b111: dec_ctrl = ALU_AND;
                    3'b001: begin
                        dec_srcb = shamt_imm;
                        if (funct7 == F7_BASE) dec_ctrl = ALU_SLL;
                        else                   dec_ill  = 1'b1;
                    end
                    default: begin
                        dec_srcb = shamt_imm;
                        if (funct7 == F7_BASE)     dec_ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_ctrl = ALU_SRA;
                        else                       dec_ill  = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_srcb = imm_u;
                dec_rw   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_srca = pc;
                dec_srcb = imm_u;
                dec_rw   = 1'b1;
            end
            OPC_LOAD: begin
                dec_srca = rs1_data;
                dec_srcb = imm_i;
                dec_rw   = 1'b1;
                // lb, lh, lw, lbu, lhu only
                dec_ill  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_srca = rs1_data;
                dec_srcb = imm_s;
                dec_ill  = funct3[2] || (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec_srca = rs1_data;
                dec_srcb = rs2_data;
                dec_br   = 1'b1;
                dec_tgt  = pc + imm_b;
                case (funct3)
                    3'b000:  dec_ctrl = ALU_BEQ;
                    3'b001:  dec_ctrl = ALU_BNE;
                    3'b100:  dec_ctrl = ALU_BLT;
                    3'b101:  dec_ctrl = ALU_BGE;
                    3'b110:  dec_ctrl = ALU_BLTU;
                    3'b111:  dec_ctrl = ALU_BGEU;
                    default: dec_ill  = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_srca = pc;
                dec_srcb = 32'd4;
                dec_rw   = 1'b1;
                dec_jp   = 1'b1;
                dec_tgt  = pc + imm_j;
            end
            OPC_JALR: begin
                dec_srca = pc;
                dec_srcb = 32'd4;
                dec_rw   = 1'b1;
                dec_jp   = 1'b1;
                dec_tgt  = {jalr_sum[31:1], 1'b0};
                dec_ill  = (funct3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase

        // An illegal instruction still flows through the stage, but must not
        // cause a write, a redirect or a meaningful ALU operation.
        if (dec_ill) begin
            dec_srca = '0;
            dec_srcb = '0;
            dec_ctrl = ALU_ADD;
            dec_rw   = 1'b0;
            dec_br   = 1'b0;
            dec_jp   = 1'b0;
            dec_tgt  = '0;
        end

        if (rd_field == 5'd0) dec_rw = 1'b0;
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    logic        valid_q, valid_d;
    logic        capture;
    logic [31:0] srca_q, srcb_q, tgt_q;
    logic [5:0]  ctrl_q;
    logic [4:0]  rd_q;
    logic        rw_q, br_q, jp_q, ill_q;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (capture)   valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            srca_q  <= '0;
            srcb_q  <= '0;
            tgt_q   <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            jp_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                srca_q <= dec_srca;
                srcb_q <= dec_srcb;
                tgt_q  <= dec_tgt;
                ctrl_q <= dec_ctrl;
                rd_q   <= rd_field;
                rw_q   <= dec_rw;
                br_q   <= dec_br;
                jp_q   <= dec_jp;
                ill_q  <= dec_ill;
            end
        end
    end

    assign out_valid     = valid_q;
    assign srca          = srca_q;
    assign srcb          = srcb_q;
    assign branch_target = tgt_q;
    assign aluCtrl       = ctrl_q;
    assign rd            = rd_q;
    assign reg_write     = rw_q;
    assign is_branch     = br_q;
    assign is_jump       = jp_q;
    assign illegal       = ill_q;

endmodule
